// File: rtl/bsr_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bsr_pkg: shared types and constants for the BSR metadata loader.          |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
package bsr_pkg;

  localparam int COL_BASE_DFLT = 128;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR    = 3'd1,
    ST_ROWPTR = 3'd2,
    ST_COLIDX = 3'd3,
    ST_READY  = 3'd4,
    ST_ERR    = 3'd5
  } state_e;

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_KT    = 3'd1;
  localparam logic [2:0] ERR_ORDER = 3'd2;
  localparam logic [2:0] ERR_NNZ   = 3'd3;
  localparam logic [2:0] ERR_COL   = 3'd4;
  localparam logic [2:0] ERR_FRAME = 3'd5;

endpackage
`default_nettype wire

// File: rtl/bsr_meta_loader_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bsr_meta_loader_if: load stream and scheduler read port bundle.           |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
interface bsr_meta_loader_if;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        s_last;
  logic        meta_ren;
  logic [31:0] meta_raddr;
  logic [31:0] meta_rdata;
  logic        meta_rvalid;

  modport master (
    output s_valid, s_data, s_last, meta_ren, meta_raddr,
    input  s_ready, meta_rdata, meta_rvalid
  );

  modport slave (
    input  s_valid, s_data, s_last, meta_ren, meta_raddr,
    output s_ready, meta_rdata, meta_rvalid
  );
endinterface
`default_nettype wire

// File: rtl/bsr_meta_ram.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bsr_meta_ram: single-port table store, sync write, registered read.       |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module bsr_meta_ram #(
  parameter int DEPTH = 1152,
  parameter int AW    = 11
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/bsr_meta_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | bsr_meta_loader: parses a BSR metadata stream into row_ptr/col_idx tables |
// | and serves scheduler reads. Revision: 1.0                                 |
// +--------------------------------------------------------------------------+
module bsr_meta_loader
  import bsr_pkg::*;
#(
  parameter int ROW_DEPTH = 128,
  parameter int COL_DEPTH = 1024,
  parameter int COL_BASE  = COL_BASE_DFLT,
  parameter int N_W       = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_start,
  input  logic            abort,
  input  logic [N_W-1:0]  NT,
  bsr_meta_loader_if.slave bus,
  output logic            loaded,
  output logic            busy,
  output logic            err,
  output logic [2:0]      err_code,
  output logic [11:0]     kt_out,
  output logic [31:0]     nnz_out
);

  localparam int DEPTH = ROW_DEPTH + COL_DEPTH;
  localparam int AW    = $clog2(DEPTH);

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] prev_q, prev_d;
  logic [31:0] nnz_q, nnz_d;
  logic [11:0] kt_q, kt_d;
  logic [2:0]  code_q, code_d;
  logic        rvalid_q, rvalid_d;
  logic        hit_q, hit_d;

  logic          w_acc;
  logic          w_last;
  logic [2:0]    w_code;
  logic          row_hit;
  logic          col_hit;
  logic [31:0]   col_off;
  logic          ram_we;
  logic          ram_re;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_rdata;

  assign bus.s_ready = (state_q == ST_HDR) || (state_q == ST_ROWPTR) ||
                       (state_q == ST_COLIDX);
  assign busy        = bus.s_ready;
  assign loaded      = (state_q == ST_READY);
  assign err         = (state_q == ST_ERR);
  assign err_code    = code_q;
  assign kt_out      = kt_q;
  assign nnz_out     = nnz_q;
  assign w_acc       = bus.s_valid & bus.s_ready;

  // Row and col windows never overlap because KT < ROW_DEPTH <= COL_BASE.
  assign col_off = bus.meta_raddr - 32'(COL_BASE);
  assign row_hit = (bus.meta_raddr <= 32'(kt_q));
  assign col_hit = (bus.meta_raddr >= 32'(COL_BASE)) && (col_off < nnz_q);

  assign rvalid_d = (state_q == ST_READY) && bus.meta_ren && !abort;
  assign hit_d    = rvalid_d && (row_hit || col_hit);
  assign ram_re   = hit_d;

  assign bus.meta_rvalid = rvalid_q;
  assign bus.meta_rdata  = hit_q ? ram_rdata : 32'd0;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prev_d   = prev_q;
    kt_d     = kt_q;
    nnz_d    = nnz_q;
    code_d   = code_q;
    w_code   = ERR_NONE;
    w_last   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = row_hit ? AW'(bus.meta_raddr) : AW'(ROW_DEPTH) + AW'(col_off);

    if (abort) begin
      state_d = ST_IDLE;
      code_d  = ERR_NONE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_READY, ST_ERR: begin
          if (load_start) begin
            state_d = ST_HDR;
            code_d  = ERR_NONE;
            cnt_d   = '0;
          end
        end
        ST_HDR: begin
          if (w_acc) begin
            if (bus.s_data == '0 || bus.s_data >= 32'(ROW_DEPTH)) begin
              w_code = ERR_KT;
            end else if (bus.s_last) begin
              w_code = ERR_FRAME;
            end
            if (w_code != ERR_NONE) begin
              state_d = ST_ERR;
              code_d  = w_code;
            end else begin
              kt_d    = bus.s_data[11:0];
              cnt_d   = '0;
              state_d = ST_ROWPTR;
            end
          end
        end
        ST_ROWPTR: begin
          if (w_acc) begin
            w_last = (cnt_q == 32'(kt_q));
            // The final row_ptr word is the last stream word only when NNZ is zero.
            if ((cnt_q == '0 && bus.s_data != '0) ||
                (cnt_q != '0 && bus.s_data < prev_q)) begin
              w_code = ERR_ORDER;
            end else if (w_last && bus.s_data > 32'(COL_DEPTH)) begin
              w_code = ERR_NNZ;
            end else if (bus.s_last != (w_last && bus.s_data == '0)) begin
              w_code = ERR_FRAME;
            end
            ram_we   = 1'b1;
            ram_addr = AW'(cnt_q);
            if (w_code != ERR_NONE) begin
              state_d = ST_ERR;
              code_d  = w_code;
            end else begin
              prev_d = bus.s_data;
              if (w_last) begin
                nnz_d   = bus.s_data;
                cnt_d   = '0;
                state_d = (bus.s_data == '0) ? ST_READY : ST_COLIDX;
              end else begin
                cnt_d = cnt_q + 32'd1;
              end
            end
          end
        end
        ST_COLIDX: begin
          if (w_acc) begin
            w_last = (cnt_q == nnz_q - 32'd1);
            if (bus.s_data >= 32'(NT)) begin
              w_code = ERR_COL;
            end else if (bus.s_last != w_last) begin
              w_code = ERR_FRAME;
            end
            ram_we   = 1'b1;
            ram_addr = AW'(ROW_DEPTH) + AW'(cnt_q);
            if (w_code != ERR_NONE) begin
              state_d = ST_ERR;
              code_d  = w_code;
            end else if (w_last) begin
              cnt_d   = '0;
              state_d = ST_READY;
            end else begin
              cnt_d = cnt_q + 32'd1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      prev_q   <= '0;
      kt_q     <= '0;
      nnz_q    <= '0;
      code_q   <= ERR_NONE;
      rvalid_q <= 1'b0;
      hit_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prev_q   <= prev_d;
      kt_q     <= kt_d;
      nnz_q    <= nnz_d;
      code_q   <= code_d;
      rvalid_q <= rvalid_d;
      hit_q    <= hit_d;
    end
  end

  bsr_meta_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (ram_addr),
    .wdata_i (bus.s_data),
    .rdata_o (ram_rdata)
  );

endmodule
`default_nettype wire

// File: tb/tb_bsr_meta_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_bsr_meta_loader: self-checking bench for bsr_meta_loader.              |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_bsr_meta_loader;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp;
  } rd_vec_t;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } sb_t;

  logic        clk;
  logic        rst;
  logic        load_start;
  logic        abort;
  logic [9:0]  NT;
  logic        loaded;
  logic        busy;
  logic        err;
  logic [2:0]  err_code;
  logic [11:0] kt_out;
  logic [31:0] nnz_out;

  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc   = 0;
  sb_t         sbq[$];
  logic [31:0] img[$];
  rd_vec_t     vecs[10];

  bsr_meta_loader_if bus ();

  bsr_meta_loader dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .abort      (abort),
    .NT         (NT),
    .bus        (bus),
    .loaded     (loaded),
    .busy       (busy),
    .err        (err),
    .err_code   (err_code),
    .kt_out     (kt_out),
    .nnz_out    (nnz_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Read-data scoreboard: every rvalid must match the oldest outstanding request.
  always @(negedge clk) begin
    sb_t it;
    if (bus.meta_rvalid === 1'b1) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL rvalid_unexpected: got rvalid=1 expected rvalid=0");
      end else begin
        it = sbq.pop_front();
        chk("rdata", bus.meta_rdata, it.data);
        chk("rd_latency", 32'(cyc - it.cyc), 32'd1);
      end
    end
  end

  task automatic start();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    int t = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = l;
    while (!bus.s_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!bus.s_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: got s_ready=0 expected s_ready=1");
    end else begin
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic send_img(input int last_idx);
    for (int i = 0; i < img.size(); i++) send(img[i], (i == last_idx));
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e);
    sb_t it;
    bus.meta_ren   = 1'b1;
    bus.meta_raddr = a;
    it.data = e;
    it.cyc  = cyc;
    sbq.push_back(it);
    @(negedge clk);
    bus.meta_ren = 1'b0;
  endtask

  task automatic drain();
    repeat (2) @(negedge clk);
    chk("sb_drained", 32'(sbq.size()), 32'd0);
  endtask

  task automatic chk_status(input string tg, input logic ld, input logic bz,
                            input logic er, input logic [2:0] cd);
    chk({tg, ".loaded"}, 32'(loaded), 32'(ld));
    chk({tg, ".busy"}, 32'(busy), 32'(bz));
    chk({tg, ".err"}, 32'(err), 32'(er));
    chk({tg, ".err_code"}, 32'(err_code), 32'(cd));
    chk({tg, ".s_ready"}, 32'(bus.s_ready), 32'(bz));
  endtask

  task automatic run_err(input string tg, input logic [2:0] cd, input int last_idx);
    start();
    send_img(last_idx);
    chk_status(tg, 1'b0, 1'b0, 1'b1, cd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{32'd0,   32'd0};
    vecs[1] = '{32'd1,   32'd2};
    vecs[2] = '{32'd2,   32'd3};
    vecs[3] = '{32'd3,   32'd0};
    vecs[4] = '{32'd127, 32'd0};
    vecs[5] = '{32'd128, 32'd1};
    vecs[6] = '{32'd129, 32'd3};
    vecs[7] = '{32'd130, 32'd0};
    vecs[8] = '{32'd131, 32'd0};
    vecs[9] = '{32'd200, 32'd0};

    rst = 1'b1; load_start = 1'b0; abort = 1'b0; NT = 10'd4;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.s_last = 1'b0;
    bus.meta_ren = 1'b0; bus.meta_raddr = '0;
    repeat (3) @(negedge clk);
    chk_status("reset", 1'b0, 1'b0, 1'b0, 3'd0);
    chk("reset.kt_out", 32'(kt_out), 32'd0);
    chk("reset.nnz_out", nnz_out, 32'd0);
    chk("reset.rvalid", 32'(bus.meta_rvalid), 32'd0);
    chk("reset.rdata", bus.meta_rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Normal image: KT=2, row_ptr {0,2,3}, col {1,3,0}
    start();
    chk("A.busy_hdr", 32'(busy), 32'd1);
    img = {32'd2, 32'd0, 32'd2, 32'd3, 32'd1, 32'd3, 32'd0};
    send_img(6);
    chk_status("A", 1'b1, 1'b0, 1'b0, 3'd0);
    chk("A.kt_out", 32'(kt_out), 32'd2);
    chk("A.nnz_out", nnz_out, 32'd3);
    for (int i = 0; i < 10; i++) rd(vecs[i].addr, vecs[i].exp);
    drain();

    // Empty rows, NNZ = 0
    start();
    chk("E.loaded_cleared", 32'(loaded), 32'd0);
    img = {32'd2, 32'd0, 32'd0, 32'd0};
    send_img(3);
    chk_status("E", 1'b1, 1'b0, 1'b0, 3'd0);
    chk("E.nnz_out", nnz_out, 32'd0);
    rd(32'd128, 32'd0);
    rd(32'd2, 32'd0);
    drain();

    img = {32'd2, 32'd0, 32'd3, 32'd2};
    run_err("errOrder", 3'd2, -1);
    NT = 10'd4;
    img = {32'd1, 32'd0, 32'd1, 32'd4};
    run_err("errCol", 3'd4, -1);
    img = {32'd1, 32'd0, 32'd1025};
    run_err("errNnz", 3'd3, -1);
    img = {32'd0};
    run_err("errKt0", 3'd1, -1);
    img = {32'd128};
    run_err("errKtBig", 3'd1, -1);
    img = {32'd2, 32'd0, 32'd2, 32'd3, 32'd1, 32'd3, 32'd0};
    run_err("errNoLast", 3'd5, -1);
    img = {32'd2, 32'd0};
    run_err("errEarlyLast", 3'd5, 1);

    // Reads are ignored outside READY
    bus.meta_ren = 1'b1; bus.meta_raddr = 32'd0;
    @(negedge clk);
    chk("err.rvalid", 32'(bus.meta_rvalid), 32'd0);
    bus.meta_ren = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("errAbort.err", 32'(err), 32'd0);

    // Abort in COLIDX
    start();
    img = {32'd2, 32'd0, 32'd2, 32'd3, 32'd1};
    send_img(-1);
    chk("abort.busy_before", 32'(busy), 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk_status("abort", 1'b0, 1'b0, 1'b0, 3'd0);
    bus.meta_ren = 1'b1; bus.meta_raddr = 32'd129;
    repeat (3) begin
      @(negedge clk);
      chk("abort.rvalid", 32'(bus.meta_rvalid), 32'd0);
    end
    bus.meta_ren = 1'b0;

    // Reset in ROWPTR with s_valid held high
    start();
    send(32'd2, 1'b0);
    send(32'd0, 1'b0);
    bus.s_valid = 1'b1; bus.s_data = 32'd2; rst = 1'b1;
    @(negedge clk);
    chk_status("rstMid", 1'b0, 1'b0, 1'b0, 3'd0);
    chk("rstMid.kt_out", 32'(kt_out), 32'd0);
    chk("rstMid.nnz_out", nnz_out, 32'd0);
    chk("rstMid.rvalid", 32'(bus.meta_rvalid), 32'd0);
    chk("rstMid.rdata", bus.meta_rdata, 32'd0);
    rst = 1'b0; bus.s_valid = 1'b0;
    @(negedge clk);

    // Reload, with a load_start pulse mid-ROWPTR that must be ignored
    start();
    send(32'd2, 1'b0);
    send(32'd0, 1'b0);
    start();
    chk("reload.busy", 32'(busy), 32'd1);
    send(32'd2, 1'b0);
    send(32'd3, 1'b0);
    send(32'd1, 1'b0);
    send(32'd3, 1'b0);
    send(32'd0, 1'b1);
    chk_status("reload", 1'b1, 1'b0, 1'b0, 3'd0);
    chk("reload.kt_out", 32'(kt_out), 32'd2);
    chk("reload.nnz_out", nnz_out, 32'd3);
    rd(32'd129, 32'd3);
    rd(32'd2, 32'd3);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
